// File: rtl/hazard_pkg.sv
// Shared constants and FSM state type for the ID-stage hazard controller.
package hazard_pkg;

    localparam int REG_W = 5;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } hz_state_t;

endpackage

// File: rtl/mdu_stall_timer.sv
// Down-counter that tracks the remaining MUL/DIV hold cycles; zero marks the release cycle.
module mdu_stall_timer #(
    parameter int MDU_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int CNT_W    = $clog2(MDU_LAT) + 1;
    // The entry cycle is already a hold cycle, so the count starts two below the latency.
    localparam int LOAD_VAL = (MDU_LAT > 1) ? (MDU_LAT - 2) : 0;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(LOAD_VAL);
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_unit.sv
// ID-stage hazard/stall controller: load-use stalls, branch flushes, MUL/DIV occupancy of EX.
// Optional HAZARD_PERF_EN adds stall_cycles/flush_count performance counters.
module hazard_unit #(
    parameter int REG_W   = hazard_pkg::REG_W,
    parameter int MDU_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] ID_rs1,
    input  logic [REG_W-1:0] ID_rs2,
    input  logic             ID_UseRs1,
    input  logic             ID_UseRs2,
    input  logic [REG_W-1:0] EX_rd,
    input  logic             EX_MemRead,
    input  logic             EX_MulDiv,
    input  logic             EX_BrTaken,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Write,
    output logic             IDEX_Flush,
    output logic             EXMEM_Bubble,
    output logic             MDU_Busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_count
`endif
);

    import hazard_pkg::*;

    localparam bit MDU_MULTI = (MDU_LAT > 1);

    hz_state_t state;
    hz_state_t state_next;
    logic      load_use;
    logic      cnt_load;
    logic      cnt_dec;
    logic      cnt_zero;

    assign load_use = EX_MemRead && (EX_rd != '0) &&
                      ((ID_UseRs1 && (EX_rd == ID_rs1)) ||
                       (ID_UseRs2 && (EX_rd == ID_rs2)));

    mdu_stall_timer #(
        .MDU_LAT (MDU_LAT)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .dec  (cnt_dec),
        .zero (cnt_zero)
    );

    always_comb begin
        PCWrite      = 1'b1;
        IFID_Write   = 1'b1;
        IFID_Flush   = 1'b0;
        IDEX_Write   = 1'b1;
        IDEX_Flush   = 1'b0;
        EXMEM_Bubble = 1'b0;
        MDU_Busy     = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        state_next   = state;
        if (rst) begin
            state_next = RUN;
        end else begin
            unique case (state)
                RUN: begin
                    if (EX_BrTaken) begin
                        // The ID instruction is killed, so a pending load-use hazard is moot.
                        IFID_Flush = 1'b1;
                        IDEX_Flush = 1'b1;
                    end else if (EX_MulDiv && MDU_MULTI) begin
                        PCWrite      = 1'b0;
                        IFID_Write   = 1'b0;
                        IDEX_Write   = 1'b0;
                        EXMEM_Bubble = 1'b1;
                        cnt_load     = 1'b1;
                        state_next   = MDU_WAIT;
                    end else if (load_use) begin
                        PCWrite    = 1'b0;
                        IFID_Write = 1'b0;
                        IDEX_Flush = 1'b1;
                    end
                end
                MDU_WAIT: begin
                    MDU_Busy = 1'b1;
                    if (!cnt_zero) begin
                        PCWrite      = 1'b0;
                        IFID_Write   = 1'b0;
                        IDEX_Write   = 1'b0;
                        EXMEM_Bubble = 1'b1;
                        cnt_dec      = 1'b1;
                    end else begin
                        // Release cycle: the finishing MUL/DIV is still in EX and must not re-arm.
                        state_next = RUN;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!PCWrite) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (IFID_Flush) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit (MDU_LAT=4 instance plus an MDU_LAT=1 instance on the same inputs).
module tb_hazard_unit;

    logic       clk;
    logic       rst;
    logic [4:0] ID_rs1;
    logic [4:0] ID_rs2;
    logic       ID_UseRs1;
    logic       ID_UseRs2;
    logic [4:0] EX_rd;
    logic       EX_MemRead;
    logic       EX_MulDiv;
    logic       EX_BrTaken;

    logic PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, EXMEM_Bubble, MDU_Busy;
    logic d1_PCWrite, d1_IFID_Write, d1_IFID_Flush, d1_IDEX_Write, d1_IDEX_Flush;
    logic d1_EXMEM_Bubble, d1_MDU_Busy;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles, flush_count;
    logic [31:0] d1_stall_cycles, d1_flush_count;
`endif

    int total = 0;
    int bad   = 0;

    // {PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, EXMEM_Bubble, MDU_Busy}
    localparam logic [6:0] NORM  = 7'b1101000;
    localparam logic [6:0] STALL = 7'b0001100;
    localparam logic [6:0] BR    = 7'b1111100;
    localparam logic [6:0] HOLD0 = 7'b0000010;
    localparam logic [6:0] WAIT  = 7'b0000011;
    localparam logic [6:0] REL   = 7'b1101001;

    logic [6:0] outs;
    logic [6:0] d1_outs;
    assign outs    = {PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, EXMEM_Bubble, MDU_Busy};
    assign d1_outs = {d1_PCWrite, d1_IFID_Write, d1_IFID_Flush, d1_IDEX_Write, d1_IDEX_Flush,
                      d1_EXMEM_Bubble, d1_MDU_Busy};

    hazard_unit #(.REG_W(5), .MDU_LAT(4)) dut (
        .clk(clk), .rst(rst),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_UseRs1(ID_UseRs1), .ID_UseRs2(ID_UseRs2),
        .EX_rd(EX_rd), .EX_MemRead(EX_MemRead), .EX_MulDiv(EX_MulDiv), .EX_BrTaken(EX_BrTaken),
        .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
        .IDEX_Write(IDEX_Write), .IDEX_Flush(IDEX_Flush), .EXMEM_Bubble(EXMEM_Bubble),
        .MDU_Busy(MDU_Busy)
`ifdef HAZARD_PERF_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    hazard_unit #(.REG_W(5), .MDU_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_UseRs1(ID_UseRs1), .ID_UseRs2(ID_UseRs2),
        .EX_rd(EX_rd), .EX_MemRead(EX_MemRead), .EX_MulDiv(EX_MulDiv), .EX_BrTaken(EX_BrTaken),
        .PCWrite(d1_PCWrite), .IFID_Write(d1_IFID_Write), .IFID_Flush(d1_IFID_Flush),
        .IDEX_Write(d1_IDEX_Write), .IDEX_Flush(d1_IDEX_Flush), .EXMEM_Bubble(d1_EXMEM_Bubble),
        .MDU_Busy(d1_MDU_Busy)
`ifdef HAZARD_PERF_EN
        , .stall_cycles(d1_stall_cycles), .flush_count(d1_flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                         input logic u2, input logic [4:0] rd, input logic mr,
                         input logic md, input logic br);
        ID_rs1     = rs1;
        ID_rs2     = rs2;
        ID_UseRs1  = u1;
        ID_UseRs2  = u2;
        EX_rd      = rd;
        EX_MemRead = mr;
        EX_MulDiv  = md;
        EX_BrTaken = br;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1);
        total++;
        if (outs !== NORM) begin
            bad++; $display("FAIL reset_hold outs=%b expected=%b", outs, NORM);
        end
        total++;
        if (d1_outs !== NORM) begin
            bad++; $display("FAIL reset_hold_lat1 outs=%b expected=%b", d1_outs, NORM);
        end
        tick();
        tick();
        rst = 1'b0;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        total++;
        if (outs !== NORM) begin
            bad++; $display("FAIL reset_after outs=%b expected=%b", outs, NORM);
        end
        tick();
    endtask

    task automatic test_load_use();
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        total++;
        if (outs !== STALL) begin
            bad++; $display("FAIL lu_rs1 outs=%b expected=%b", outs, STALL);
        end
        tick();
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        total++;
        if (outs !== NORM) begin
            bad++; $display("FAIL lu_after outs=%b expected=%b", outs, NORM);
        end
        tick();
        drive(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        total++;
        if (outs !== STALL) begin
            bad++; $display("FAIL lu_rs2 outs=%b expected=%b", outs, STALL);
        end
        tick();
        drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        total++;
        if (outs !== NORM) begin
            bad++; $display("FAIL lu_rd0 outs=%b expected=%b", outs, NORM);
        end
        tick();
        drive(5'd3, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        total++;
        if (outs !== NORM) begin
            bad++; $display("FAIL lu_rs2_unused outs=%b expected=%b", outs, NORM);
        end
        tick();
        drive(5'd21, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        total++;
        if (outs !== NORM) begin
            bad++; $display("FAIL lu_msb_differs outs=%b expected=%b", outs, NORM);
        end
        tick();
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
        total++;
        if (outs !== NORM) begin
            bad++; $display("FAIL lu_not_load outs=%b expected=%b", outs, NORM);
        end
        tick();
    endtask

    task automatic test_branch();
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1);
        total++;
        if (outs !== BR) begin
            bad++; $display("FAIL br_over_lu outs=%b expected=%b", outs, BR);
        end
        tick();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        total++;
        if (outs !== NORM) begin
            bad++; $display("FAIL br_after outs=%b expected=%b", outs, NORM);
        end
        tick();
    endtask

    task automatic test_mdu();
        logic [6:0] seq_exp [0:7];
        seq_exp = '{HOLD0, WAIT, WAIT, REL, HOLD0, WAIT, WAIT, REL};
        for (int i = 0; i < 8; i++) begin
            if (i == 1) begin
                // Load-use and redirect must be ignored while waiting.
                drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1);
            end else begin
                drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, (i <= 4) ? 1'b1 : 1'b0, 1'b0);
            end
            total++;
            if (outs !== seq_exp[i]) begin
                bad++; $display("FAIL mdu_cycle%0d outs=%b expected=%b", i + 1, outs, seq_exp[i]);
            end
            if (i != 1) begin
                total++;
                if (d1_outs !== NORM) begin
                    bad++; $display("FAIL mdu_lat1_cycle%0d outs=%b expected=%b", i + 1, d1_outs, NORM);
                end
            end
            tick();
        end
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        total++;
        if (outs !== NORM) begin
            bad++; $display("FAIL mdu_back_to_run outs=%b expected=%b", outs, NORM);
        end
        tick();
    endtask

    task automatic test_rst_abort();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick();
        total++;
        if (outs !== WAIT) begin
            bad++; $display("FAIL abort_wait outs=%b expected=%b", outs, WAIT);
        end
        rst = 1'b1;
        #1;
        total++;
        if (outs !== NORM) begin
            bad++; $display("FAIL abort_rst outs=%b expected=%b", outs, NORM);
        end
        tick();
        rst = 1'b0;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        total++;
        if (outs !== NORM) begin
            bad++; $display("FAIL abort_run outs=%b expected=%b", outs, NORM);
        end
        tick();
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf();
        rst = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        total++;
        if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
            bad++; $display("FAIL perf_reset stall=%0d flush=%0d expected=0/0", stall_cycles, flush_count);
        end
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        total++;
        if (stall_cycles !== 32'd4) begin
            bad++; $display("FAIL perf_stall got=%0d expected=4", stall_cycles);
        end
        total++;
        if (flush_count !== 32'd1) begin
            bad++; $display("FAIL perf_flush got=%0d expected=1", flush_count);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        test_reset();
        test_load_use();
        test_branch();
        test_mdu();
        test_rst_abort();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
